proc_io_hub: RTL
================

// Module: proc_io_hub
// PURPOSE
//   Parametrised I/O hub between a proc_fl core and external streaming channels; replaces the bare addr_dec pair.
//   Input side: one holding register per channel with valid/ready capture; the core reads via addr_in/req_in.
//   Output side: one FIFO per channel fed by addr_out/out_en and drained by valid/ready.
//   Data words are opaque NBITS vectors (float format); int2float/float2int stay outside.
// PARAMETERS
//   NUIOIN  4   number of input channels (>=1)
//   NUIOOU  4   number of output channels (>=1)
//   NBITS   28  data word width (NBMANT+NBEXPO+1)
//   FDEPTH  4   output FIFO depth per channel (power of 2, >=2)
// PORTS
//   clk            in   1                single clock, rising edge
//   rst            in   1                synchronous reset, active high
//   proc_req_in    in   1                core reads input channel proc_addr_in this cycle
//   proc_addr_in   in   $clog2(NUIOIN)   input channel select (width 1 when NUIOIN==1)
//   proc_in        out  NBITS            data returned to core
//   proc_out_en    in   1                core writes proc_out to channel proc_addr_out
//   proc_addr_out  in   $clog2(NUIOOU)   output channel select (width 1 when NUIOOU==1)
//   proc_out       in   NBITS            data from core
//   ext_in_data    in   NUIOIN*NBITS     channel i at [i*NBITS +: NBITS]
//   ext_in_valid   in   NUIOIN           per-channel valid
//   ext_in_ready   out  NUIOIN           per-channel ready
//   ext_out_data   out  NUIOOU*NBITS     FIFO head per channel
//   ext_out_valid  out  NUIOOU           FIFO non-empty
//   ext_out_ready  in   NUIOOU           consumer accepts head
//   clr_flags      in   1                clears sticky flags
//   underrun       out  NUIOIN           sticky: read of empty input channel
//   overflow       out  NUIOOU           sticky: write to full output FIFO dropped
// BEHAVIOUR
//   Reset: hold regs=0, full=0, FIFO ptrs/counts=0, flags=0 -> ext_in_ready=all 1, ext_out_valid=0, proc_in=0.
//   Input channel i: ext_in_ready[i] = ~full[i] | (proc_req_in & proc_addr_in==i) (read frees slot same cycle).
//     Capture on valid&ready: hold<=data, full<=1. Read w/o capture: full<=0. Read+capture same cycle: full stays 1, new data.
//     proc_in = combinational mux of hold[proc_addr_in]; captured word readable the cycle after capture.
//     Read of empty channel returns last held value (0 after reset), sets underrun[i].
//     proc_addr_in >= NUIOIN: proc_in=0, no state change, no flag.
//   Output channel j: push on proc_out_en & proc_addr_out==j; pop on ext_out_valid[j]&ext_out_ready[j].
//     Push visible as ext_out_valid the next cycle (no fall-through). ext_out_data[j] = registered FIFO head.
//     Full + push without pop: word dropped, overflow[j] set. Full + push + pop same cycle: both accepted, count unchanged.
//     Empty + pop impossible (valid=0). Pointers wrap modulo FDEPTH; count 0..FDEPTH.
//     proc_addr_out >= NUIOOU: write dropped silently.
//   Flags: set has priority over clr_flags in the same cycle.
//   rst mid-transfer: all buffered words discarded; no partial state survives.
//   No core back-pressure: the core never stalls; loss is reported only via flags.
// CONFIGURATION
//   IO_HUB_ERRFLAG_EN defined: underrun/overflow sticky registers implemented, clr_flags honoured.
//   Not defined: underrun/overflow tied to 0, clr_flags ignored; datapath behaviour identical.
// TESTING
//   Reset then idle -> ext_in_ready=4'b1111, ext_out_valid=0, proc_in=0, flags=0.
//   ch2 valid with 28'h0ABCDEF, next cycle req_in addr 2 -> proc_in=28'h0ABCDEF, ext_in_ready[2] low between, high after read.
//   Read ch1 and capture 28'h1111111 same cycle while full -> old word returned, ch1 stays full with new word, no flag.
//   4 pushes to ch0 with ready=0, 5th push -> ch0 holds 4 words, overflow[0]=1; drain returns words in order, 5th absent.
//   ch3 full, push+pop same cycle -> count stays 4, order preserved, overflow[3]=0.
//   Read empty ch0 -> underrun[0]=1 (0 without IO_HUB_ERRFLAG_EN); clr_flags -> 0; rst with data buffered -> all empty.

Source files
------------

// File: rtl/proc_io_hub.sv
// -----------------------------------------------------------------------------
// proc_io_hub
//
// Purpose:
//   I/O hub between a proc_fl core and external streaming channels.
//   Input side : one holding register per channel. The external producer hands
//                a word over with valid/ready, and the core reads it with
//                proc_req_in/proc_addr_in. A read frees the slot in the same
//                cycle, so a new word can be captured while the old one is read.
//   Output side: one FIFO per channel. The core fills it with
//                proc_out_en/proc_addr_out, and the external consumer drains it
//                with valid/ready.
//   Data words are opaque NBITS vectors. The core is never stalled; any word
//   that is lost is reported through the sticky flags.
//
// Configuration macro:
//   IO_HUB_ERRFLAG_EN - when defined, the underrun/overflow sticky registers
//                       are built and clr_flags clears them. When undefined,
//                       both flag outputs are tied to 0 and clr_flags is unused.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   proc_req_in/proc_addr_in  core read strobe and input channel select
//   proc_in                   data returned to the core (combinational mux)
//   proc_out_en/proc_addr_out core write strobe and output channel select
//   proc_out                  data written by the core
//   ext_in_data/valid/ready   input streams, channel i at [i*NBITS +: NBITS]
//   ext_out_data/valid/ready  output streams, showing the FIFO head per channel
//   clr_flags                 clears the sticky flags (a set in the same cycle wins)
//   underrun                  sticky per input channel: read of an empty slot
//   overflow                  sticky per output channel: push dropped because full
// -----------------------------------------------------------------------------
module proc_io_hub #(
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int NBITS  = 28,
  parameter int FDEPTH = 4,
  localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AIW-1:0]           proc_addr_in,
  output logic [NBITS-1:0]         proc_in,
  input  logic                     proc_out_en,
  input  logic [AOW-1:0]           proc_addr_out,
  input  logic [NBITS-1:0]         proc_out,
  input  logic [NUIOIN*NBITS-1:0]  ext_in_data,
  input  logic [NUIOIN-1:0]        ext_in_valid,
  output logic [NUIOIN-1:0]        ext_in_ready,
  output logic [NUIOOU*NBITS-1:0]  ext_out_data,
  output logic [NUIOOU-1:0]        ext_out_valid,
  input  logic [NUIOOU-1:0]        ext_out_ready,
  input  logic                     clr_flags,
  output logic [NUIOIN-1:0]        underrun,
  output logic [NUIOOU-1:0]        overflow
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = $clog2(FDEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  logic [NBITS-1:0]  hold_reg [NUIOIN];
  logic [NUIOIN-1:0] full_reg;
  logic [NUIOIN-1:0] underrun_set;

  genvar gi;
  generate
    for (gi = 0; gi < NUIOIN; gi++) begin : g_in
      logic rd_hit;
      logic capture;

      // Addresses that match no channel produce no hit, so an out-of-range
      // read has no effect on any channel.
      assign rd_hit  = proc_req_in & (proc_addr_in == AIW'(gi));
      // A read in this cycle frees the slot, so the producer may refill it
      // in the same cycle.
      assign ext_in_ready[gi] = ~full_reg[gi] | rd_hit;
      assign capture = ext_in_valid[gi] & ext_in_ready[gi];
      assign underrun_set[gi] = rd_hit & ~full_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_reg[gi] <= '0;
          full_reg[gi] <= 1'b0;
        end else if (capture) begin
          hold_reg[gi] <= ext_in_data[gi*NBITS +: NBITS];
          full_reg[gi] <= 1'b1;
        end else if (rd_hit) begin
          // The word is kept, so a later empty read returns the last value.
          full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Read mux. An address beyond the last channel returns 0.
  always_comb begin
    proc_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (proc_addr_in == AIW'(i)) begin
        proc_in = hold_reg[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output side: one FIFO per channel
  // ---------------------------------------------------------------------------
  logic [NUIOOU-1:0] overflow_set;

  generate
    for (gi = 0; gi < NUIOOU; gi++) begin : g_out
      logic [NBITS-1:0] mem_reg [FDEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push;
      logic             pop;
      logic             fifo_full;
      logic             do_push;

      assign push      = proc_out_en & (proc_addr_out == AOW'(gi));
      assign ext_out_valid[gi] = (count_reg != '0);
      assign pop       = ext_out_valid[gi] & ext_out_ready[gi];
      assign fifo_full = (count_reg == CW'(FDEPTH));
      // When the FIFO is full, a pop in the same cycle frees the slot that
      // the push needs.
      assign do_push   = push & (~fifo_full | pop);
      assign overflow_set[gi] = push & fifo_full & ~pop;

      // The head comes from the storage array. A push updates both the array
      // and the count at the clock edge, so a word can never appear on the
      // output in the same cycle it is pushed.
      assign ext_out_data[gi*NBITS +: NBITS] = mem_reg[rd_ptr_reg];

      // The storage has no reset. Clearing the pointers and the count is
      // enough to discard its contents.
      always_ff @(posedge clk) begin
        if (do_push) begin
          mem_reg[wr_ptr_reg] <= proc_out;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          if (do_push && !pop) begin
            count_reg <= count_reg + CW'(1);
          end else if (pop && !do_push) begin
            count_reg <= count_reg - CW'(1);
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef IO_HUB_ERRFLAG_EN
  logic [NUIOIN-1:0] underrun_reg;
  logic [NUIOOU-1:0] overflow_reg;

  // A set in the same cycle takes priority over clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_reg <= '0;
      overflow_reg <= '0;
    end else begin
      underrun_reg <= (underrun_reg & {NUIOIN{~clr_flags}}) | underrun_set;
      overflow_reg <= (overflow_reg & {NUIOOU{~clr_flags}}) | overflow_set;
    end
  end

  assign underrun = underrun_reg;
  assign overflow = overflow_reg;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = clr_flags | (|underrun_set) | (|overflow_set);
  assign underrun = '0;
  assign overflow = '0;
`endif

endmodule
